// File: rtl/dmem_ctrl_if.sv
// Request/response bus between a core and the dmem_ctrl data-memory controller.
interface dmem_ctrl_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_stack;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_stack, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_stack, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with fixed-latency, strictly serialised little-endian accesses.
// Optional stack-region guard enabled by defining DMEM_STACK_GUARD_EN.
module dmem_ctrl #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned STACK_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_ctrl_if.slave bus
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(DEPTH - NB);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        mem_q [DEPTH];

    logic              enter_resp_c;
    logic              op_we_c;
    logic [ADDR_W-1:0] op_addr_c;
    logic [DATA_W-1:0] op_wdata_c;
    logic              err_c;
    logic              wr_en_c;
    logic [IW-1:0]     idx_c;
    logic [DATA_W-1:0] rd_word_c;

`ifdef DMEM_STACK_GUARD_EN
    localparam logic [ADDR_W:0] STACK_LO = (ADDR_W+1)'(DEPTH - STACK_BYTES);
    logic            stack_q, stack_d;
    logic            op_stack_c;
    logic [ADDR_W:0] op_end_c;
`else
    logic            unused_stack_c;
    assign unused_stack_c = bus.req_stack;
`endif

    // With LATENCY=1 the access completes on the accept edge, so use live inputs in IDLE
    always_comb begin
        op_we_c    = (state_q == IDLE) ? bus.req_we    : we_q;
        op_addr_c  = (state_q == IDLE) ? bus.req_addr  : addr_q;
        op_wdata_c = (state_q == IDLE) ? bus.req_wdata : wdata_q;
        err_c      = (op_addr_c > LAST_OK);
`ifdef DMEM_STACK_GUARD_EN
        op_stack_c = (state_q == IDLE) ? bus.req_stack : stack_q;
        op_end_c   = {1'b0, op_addr_c} + (ADDR_W+1)'(NB);
        if (op_stack_c) begin
            err_c = err_c | ({1'b0, op_addr_c} < STACK_LO);
        end else begin
            err_c = err_c | (op_end_c > STACK_LO);
        end
`endif
        idx_c = op_addr_c[IW-1:0];
        rd_word_c = '0;
        for (int k = 0; k < int'(NB); k++) begin
            rd_word_c[8*k +: 8] = mem_q[idx_c + IW'(k)];
        end
    end

    // Next-state, request latch and registered response
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        enter_resp_c = 1'b0;
`ifdef DMEM_STACK_GUARD_EN
        stack_d      = stack_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (ready_q && bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
`ifdef DMEM_STACK_GUARD_EN
                    stack_d = bus.req_stack;
`endif
                    if (LATENCY <= 1) begin
                        state_d      = RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d      = RESP;
                    enter_resp_c = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
        err_d   = err_q;
        rdata_d = rdata_q;
        if (enter_resp_c) begin
            err_d   = err_c;
            rdata_d = (op_we_c || err_c) ? '0 : rd_word_c;
        end
        wr_en_c = enter_resp_c && op_we_c && !err_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DMEM_STACK_GUARD_EN
            stack_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef DMEM_STACK_GUARD_EN
            stack_q <= stack_d;
`endif
        end
    end

    // Storage array is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int k = 0; k < int'(NB); k++) begin
                mem_q[idx_c + IW'(k)] <= op_wdata_c[8*k +: 8];
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: three instances (LATENCY 2, 3, 1) share one stimulus bus.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_we, req_stack;
    logic [63:0] req_addr, req_wdata;

    dmem_ctrl_if #(.DATA_W(64), .ADDR_W(64)) if0 ();
    dmem_ctrl_if #(.DATA_W(64), .ADDR_W(64)) if3 ();
    dmem_ctrl_if #(.DATA_W(64), .ADDR_W(64)) if1 ();

    assign if0.req_valid = req_valid;  assign if3.req_valid = req_valid;  assign if1.req_valid = req_valid;
    assign if0.req_we    = req_we;     assign if3.req_we    = req_we;     assign if1.req_we    = req_we;
    assign if0.req_stack = req_stack;  assign if3.req_stack = req_stack;  assign if1.req_stack = req_stack;
    assign if0.req_addr  = req_addr;   assign if3.req_addr  = req_addr;   assign if1.req_addr  = req_addr;
    assign if0.req_wdata = req_wdata;  assign if3.req_wdata = req_wdata;  assign if1.req_wdata = req_wdata;

    dmem_ctrl #(.DATA_W(64), .ADDR_W(64), .DEPTH(2048), .LATENCY(2), .STACK_BYTES(64))
        dut (.clk(clk), .rst_n(rst_n), .bus(if0));
    dmem_ctrl #(.DATA_W(64), .ADDR_W(64), .DEPTH(2048), .LATENCY(3), .STACK_BYTES(64))
        dut_l3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    dmem_ctrl #(.DATA_W(64), .ADDR_W(64), .DEPTH(2048), .LATENCY(1), .STACK_BYTES(64))
        dut_l1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl [2048];
    int         checks = 0;
    int         failures = 0;

    function automatic logic model_err(input logic st, input logic [63:0] a);
        logic e;
        e = (a > 64'd2040);
`ifdef DMEM_STACK_GUARD_EN
        if (!e) begin
            if (st) e = (a < 64'd1984);
            else    e = (a + 64'd8 > 64'd1984);
        end
`endif
        return e;
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = mdl[int'(a[10:0]) + k];
        return r;
    endfunction

    // One access on the LATENCY=2 instance; called and returns on a negedge
    task automatic access(input logic we, input logic st, input logic [63:0] a,
                          input logic [63:0] wd, input string name);
        exp_t e, got;
        int   n;
        n = 0;
        while (if0.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (if0.req_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL %s: req_ready timeout", name);
            return;
        end
        e.err   = model_err(st, a);
        e.rdata = (we || e.err) ? 64'd0 : model_read(a);
        if (we && !e.err) for (int k = 0; k < 8; k++) mdl[int'(a[10:0]) + k] = wd[8*k +: 8];
        sb.push_back(e);
        req_valid = 1'b1; req_we = we; req_stack = st; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (if0.resp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, want 2", name, n);
        end
        if (if0.resp_valid !== 1'b1) begin
            void'(sb.pop_front());
            return;
        end
        got = sb.pop_front();
        checks++;
        if (if0.resp_rdata !== got.rdata) begin
            failures++;
            $display("FAIL %s rdata: got %h want %h", name, if0.resp_rdata, got.rdata);
        end
        checks++;
        if (if0.resp_err !== got.err) begin
            failures++;
            $display("FAIL %s err: got %b want %b", name, if0.resp_err, got.err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 4;
        if (if0.req_ready !== 1'b0)   begin failures++; $display("FAIL rst ready: got %b want 0", if0.req_ready); end
        if (if0.resp_valid !== 1'b0)  begin failures++; $display("FAIL rst valid: got %b want 0", if0.resp_valid); end
        if (if0.resp_rdata !== 64'd0) begin failures++; $display("FAIL rst rdata: got %h want 0", if0.resp_rdata); end
        if (if0.resp_err !== 1'b0)    begin failures++; $display("FAIL rst err: got %b want 0", if0.resp_err); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (if0.req_ready !== 1'b0) begin failures++; $display("FAIL rst release ready: got %b want 0", if0.req_ready); end
        @(negedge clk);
        checks++;
        if (if0.req_ready !== 1'b1) begin failures++; $display("FAIL rst first edge ready: got %b want 1", if0.req_ready); end
    endtask

    task automatic test_endian();
        access(1'b1, 1'b0, 64'h18, 64'h0, "init18");
        access(1'b1, 1'b0, 64'h10, 64'h1122334455667788, "wr10");
        access(1'b0, 1'b0, 64'h10, 64'h0, "rd10");
        access(1'b0, 1'b0, 64'h13, 64'h0, "rd13");
    endtask

    task automatic test_bounds();
        access(1'b1, 1'b0, 64'd2040, 64'hCAFEBABEDEADBEEF, "wr2040");
        access(1'b0, 1'b0, 64'd2040, 64'h0, "rd2040");
        access(1'b0, 1'b0, 64'd2041, 64'h0, "rd2041");
        access(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0123456789ABCDEF, "wr_huge");
        access(1'b0, 1'b0, 64'd2040, 64'h0, "rd2040_after");
        access(1'b0, 1'b0, 64'h0000000100000000, 64'h0, "rd_hi_bit");
    endtask

    task automatic test_stack_guard();
        access(1'b1, 1'b0, 64'd1984, 64'h0101010101010101, "ns_wr1984");
        access(1'b1, 1'b1, 64'd1984, 64'h0202020202020202, "st_wr1984");
        access(1'b0, 1'b1, 64'd1976, 64'h0, "st_rd1976");
        access(1'b0, 1'b1, 64'd1984, 64'h0, "st_rd1984");
    endtask

    task automatic test_reset_abort();
        int seen;
        access(1'b1, 1'b0, 64'h40, 64'h5555555555555555, "wr40");
        req_valid = 1'b1; req_we = 1'b1; req_stack = 1'b0; req_addr = 64'h40;
        req_wdata = 64'hAAAAAAAAAAAAAAAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (if0.resp_valid !== 1'b0) seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (if0.resp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL abort resp_valid: got %0d pulses want 0", seen); end
        access(1'b0, 1'b0, 64'h40, 64'h0, "rd40_after_abort");
    endtask

    task automatic test_latency3();
        int n;
        n = 0;
        while (if3.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = 1'b0; req_stack = 1'b0; req_addr = 64'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks += 2;
            if (if3.req_ready !== (c == 4)) begin
                failures++; $display("FAIL lat3 ready c%0d: got %b want %b", c, if3.req_ready, (c == 4));
            end
            if (if3.resp_valid !== (c == 3)) begin
                failures++; $display("FAIL lat3 valid c%0d: got %b want %b", c, if3.resp_valid, (c == 3));
            end
            if (c < 4) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int   n, acc, rsp;
        exp_t got;
        n = 0;
        while (if1.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        acc = 0; rsp = 0;
        sb.delete();
        req_valid = 1'b1; req_we = 1'b1; req_stack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_addr = 64'h100 + 64'(8 * i); req_wdata = 64'(i + 1);
            checks++;
            if (if1.req_ready !== (i % 2 == 0)) begin
                failures++; $display("FAIL b2b ready i%0d: got %b want %b", i, if1.req_ready, (i % 2 == 0));
            end
            if (if1.req_ready === 1'b1) begin acc++; sb.push_back('{rdata: 64'd0, err: 1'b0}); end
            @(posedge clk);
            @(negedge clk);
            if (if1.resp_valid === 1'b1) begin
                rsp++;
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL b2b resp without request i%0d", i);
                end else begin
                    got = sb.pop_front();
                    if (if1.resp_rdata !== got.rdata || if1.resp_err !== got.err) begin
                        failures++;
                        $display("FAIL b2b resp i%0d: got %h/%b want %h/%b", i, if1.resp_rdata,
                                 if1.resp_err, got.rdata, got.err);
                    end
                end
            end
        end
        req_valid = 1'b0;
        checks += 2;
        if (acc !== 5) begin failures++; $display("FAIL b2b accepts: got %0d want 5", acc); end
        if (rsp !== 5) begin failures++; $display("FAIL b2b responses: got %0d want 5", rsp); end
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_stack = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 2048; i++) mdl[i] = 8'h00;
        test_reset();
        test_endian();
        test_bounds();
        test_stack_guard();
        test_reset_abort();
        test_latency3();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
